// File: rtl/life_grid_scheduler.sv
// rtl/life_grid_scheduler.sv - Clear/edit/sweep/swap sequencer for the double-buffered Life grid
// Optional single-step input enabled by defining STEP_MODE_EN.
module life_grid_scheduler #(
    parameter int GRID_W   = 80,
    parameter int GRID_H   = 48,
    parameter int ADDR_W   = 12,
    parameter int TICK_DIV = 5000000,
    parameter int GEN_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        xcoordinate,
    input  logic [7:0]        ycoordinate,
    input  logic              coordinatesready,
    input  logic              clearreq,
`ifdef STEP_MODE_EN
    input  logic              step,
`endif
    output logic              eng_valid,
    output logic [7:0]        eng_x,
    output logic [7:0]        eng_y,
    input  logic              eng_ready,
    input  logic              eng_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              wr_bank,
    output logic              cur_bank,
    output logic [GEN_W-1:0]  gen_count,
    output logic [2:0]        phase,
    output logic              busy
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);
    localparam logic [7:0]        X_LAST    = 8'(GRID_W - 1);
    localparam logic [7:0]        Y_LAST    = 8'(GRID_H - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        EDIT  = 3'd2,
        SWEEP = 3'd3,
        DRAIN = 3'd4,
        SWAP  = 3'd5
    } state_t;

    state_t            state;
    logic [TW-1:0]     tick;
    logic              coord_hist;
    logic              clear_hist;
    logic              clear_pend;
    logic              edit_pend;
    logic [7:0]        edit_x;
    logic [7:0]        edit_y;
    logic              coord_ok;
    logic              sweep_go;
    logic [ADDR_W-1:0] edit_addr;

    assign phase     = state;
    assign busy      = (state != IDLE);
    assign coord_ok  = (int'(xcoordinate) < GRID_W) && (int'(ycoordinate) < GRID_H);
    assign edit_addr = ADDR_W'(edit_y) * ADDR_W'(GRID_W) + ADDR_W'(edit_x);

`ifdef STEP_MODE_EN
    logic step_hist;
    logic step_pend;
    assign sweep_go = (start && tick == TICK_LAST) || (step_pend && !start);
`else
    assign sweep_go = start && (tick == TICK_LAST);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tick       <= '0;
            cur_bank   <= 1'b0;
            gen_count  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 1'b0;
            wr_bank    <= 1'b0;
            eng_valid  <= 1'b0;
            eng_x      <= '0;
            eng_y      <= '0;
            clear_pend <= 1'b0;
            edit_pend  <= 1'b0;
            edit_x     <= '0;
            edit_y     <= '0;
            coord_hist <= coordinatesready;
            clear_hist <= clearreq;
`ifdef STEP_MODE_EN
            step_hist  <= step;
            step_pend  <= 1'b0;
`endif
        end else begin
            coord_hist <= coordinatesready;
            clear_hist <= clearreq;
`ifdef STEP_MODE_EN
            step_hist  <= step;
`endif
            case (state)
                IDLE: begin
                    if (start && tick != TICK_LAST)
                        tick <= tick + TW'(1);
                    if (clear_pend) begin
                        state   <= CLEAR;
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= 1'b0;
                        wr_bank <= cur_bank;
                    end else if (edit_pend) begin
                        // Cleared on entry so an edit landing this same edge stays queued
                        state     <= EDIT;
                        edit_pend <= 1'b0;
                        wr_en     <= 1'b1;
                        wr_addr   <= edit_addr;
                        wr_data   <= 1'b1;
                        wr_bank   <= cur_bank;
                    end else if (sweep_go) begin
                        state     <= SWEEP;
                        tick      <= '0;
                        eng_valid <= 1'b1;
                        eng_x     <= '0;
                        eng_y     <= '0;
`ifdef STEP_MODE_EN
                        step_pend <= 1'b0;
`endif
                    end
                end
                CLEAR: begin
                    if (wr_addr == LAST_ADDR) begin
                        wr_en      <= 1'b0;
                        clear_pend <= 1'b0;
                        gen_count  <= '0;
                        tick       <= '0;
                        state      <= IDLE;
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
                EDIT: begin
                    wr_en <= 1'b0;
                    state <= IDLE;
                end
                SWEEP: begin
                    if (eng_ready) begin
                        if (eng_x != X_LAST) begin
                            eng_x <= eng_x + 8'd1;
                        end else if (eng_y != Y_LAST) begin
                            eng_x <= '0;
                            eng_y <= eng_y + 8'd1;
                        end else begin
                            eng_valid <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!eng_busy)
                        state <= SWAP;
                end
                SWAP: begin
                    cur_bank  <= ~cur_bank;
                    gen_count <= gen_count + GEN_W'(1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Event capture comes last so a fresh toggle wins over a same-edge service
            if (clearreq != clear_hist)
                clear_pend <= 1'b1;
            if (coordinatesready != coord_hist && coord_ok) begin
                edit_pend <= 1'b1;
                edit_x    <= xcoordinate;
                edit_y    <= ycoordinate;
            end
`ifdef STEP_MODE_EN
            if (step != step_hist && !start)
                step_pend <= 1'b1;
`endif
        end
    end

endmodule
